// File: rtl/b08_log_pkg.sv
// Shared types and field layout for the b08 result logger.
package b08_log_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int TO_BIT  = 7;
    localparam int SEQ_MSB = 6;
    localparam int SEQ_LSB = 4;
    localparam int RES_MSB = 3;
    localparam int ENTRY_W = 8;

    typedef struct packed {
        logic       timeout;
        logic [2:0] seq;
        logic [3:0] result;
    } entry_t;

    function automatic entry_t make_entry(input logic to, input logic [2:0] seq,
                                          input logic [3:0] res);
        entry_t e;
        e.timeout = to;
        e.seq     = seq;
        e.result  = res;
        return e;
    endfunction

endpackage

// File: rtl/b08_log_fifo.sv
// First-word-fall-through FIFO; pointers carry an extra wrap bit to tell full from empty.
module b08_log_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [LW-1:0]    level_o,
    output logic             accepted_o,
    output logic             dropped_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             empty_s, full_s, pop_s;

    assign empty_s = (wr_q == rd_q);
    assign full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_s   = pop_i & ~empty_s;
    // A pop frees the slot the same cycle, so a push on full is still accepted.
    assign accepted_o = push_i & (~full_s | pop_s);
    assign dropped_o  = push_i & full_s & ~pop_s;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (accepted_o) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accepted_o) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    assign valid_o = ~empty_s;
    assign data_o  = empty_s ? {WIDTH{1'b0}} : mem_q[rd_q[AW-1:0]];
    assign level_o = LW'(wr_q - rd_q);

endmodule

// File: rtl/b08_result_logger.sv
// Captures one tagged result per START session of the b08 engine and queues it for readout.
module b08_result_logger
    import b08_log_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     START,
    input  logic [3:0]               O_IN,
    input  logic                     OUT_READY,
    output logic                     OUT_VALID,
    output logic [7:0]               OUT_DATA,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic [CNT_W-1:0]         COUNT,
    output logic                     OVERFLOW,
    output logic                     BUSY
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       base_q, base_d;
    logic [2:0]       seq_q, seq_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push_s, push_to_s, changed_s, accepted_s, dropped_s;
    entry_t           entry_s;

    assign changed_s = (O_IN != base_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result change has priority over abort, which has priority over timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (START) state_d = ARMED;
                else       state_d = IDLE;
            end
            ARMED: begin
                if (!START) state_d = WAIT;
                else        state_d = ARMED;
            end
            WAIT: begin
                if (changed_s)                  state_d = IDLE;
                else if (START)                 state_d = ARMED;
                else if (timer_q == TIMER_LAST) state_d = IDLE;
                else                            state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_s    = 1'b0;
        push_to_s = 1'b0;
        if (state_q == WAIT) begin
            if (changed_s) begin
                push_s    = 1'b1;
                push_to_s = 1'b0;
            end else if (START || (timer_q == TIMER_LAST)) begin
                push_s    = 1'b1;
                push_to_s = 1'b1;
            end else begin
                push_s    = 1'b0;
                push_to_s = 1'b0;
            end
        end else begin
            push_s    = 1'b0;
            push_to_s = 1'b0;
        end
    end

    assign entry_s = make_entry(push_to_s, seq_q, O_IN);

    b08_log_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .push_i     (push_s),
        .data_i     (entry_s),
        .pop_i      (OUT_READY),
        .valid_o    (OUT_VALID),
        .data_o     (OUT_DATA),
        .level_o    (LEVEL),
        .accepted_o (accepted_s),
        .dropped_o  (dropped_s)
    );

    always_comb begin
        timer_d = timer_q;
        base_d  = base_q;
        if (state_q == ARMED) begin
            timer_d = '0;
            base_d  = O_IN;
        end else if ((state_q == WAIT) && !push_s) begin
            timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            base_d  = base_q;
        end else begin
            timer_d = timer_q;
            base_d  = base_q;
        end
        // Dropped pushes still consume a tag so gaps in the sequence reveal loss.
        seq_d = push_s ? (seq_q + 3'd1) : seq_q;
        if (accepted_s && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        ovf_d = ovf_q | dropped_s;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
            base_q  <= 4'd0;
            seq_q   <= 3'd0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            base_q  <= base_d;
            seq_q   <= seq_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign COUNT    = count_q;
    assign OVERFLOW = ovf_q;
    assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_b08_result_logger.sv
// Scoreboard bench for b08_result_logger: session-level stimulus predicts entries, a monitor checks readout.
module tb_b08_result_logger;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             START = 1'b0;
    logic [3:0]       O_IN = 4'd0;
    logic             OUT_READY = 1'b0;
    logic             OUT_VALID;
    logic [7:0]       OUT_DATA;
    logic [3:0]       LEVEL;
    logic [CNT_W-1:0] COUNT;
    logic             OVERFLOW;
    logic             BUSY;

    b08_result_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .START     (START),
        .O_IN      (O_IN),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .LEVEL     (LEVEL),
        .COUNT     (COUNT),
        .OVERFLOW  (OVERFLOW),
        .BUSY      (BUSY)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] sb_q[$];
    int         seq_m = 0;
    int         exp_count = 0;
    bit         exp_ovf = 1'b0;
    bit         exp_push = 1'b0;
    logic [7:0] exp_entry = 8'h00;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input bit to, input logic [3:0] res);
        logic [2:0] s;
        s = seq_m[2:0];
        exp_entry = {to, s, res};
        exp_push = 1'b1;
        seq_m++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        START = 1'b0;
        step();
        reset = 1'b0;
        seq_m = 0;
    endtask

    function automatic logic [3:0] diff_val(input logic [3:0] b);
        logic [3:0] x;
        x = 4'($urandom_range(1, 15));
        return b ^ x;
    endfunction

    // One START session: START high for hold cycles, then O_IN becomes val d cycles into the wait.
    task automatic session(input int hold, input int d, input logic [3:0] val, input bit ready_at_push);
        logic [3:0] base;
        base = O_IN;
        START = 1'b1;
        repeat (hold) step();
        START = 1'b0;
        step();
        for (int j = 0; j < TIMEOUT; j++) begin
            if (j == d) O_IN = val;
            if (j == 0) check("busy_in_wait", BUSY, 1);
            if ((O_IN != base) || (j == TIMEOUT - 1)) begin
                request(O_IN == base, O_IN);
                if (ready_at_push) OUT_READY = 1'b1;
                step();
                exp_push = 1'b0;
                if (ready_at_push) OUT_READY = 1'b0;
                break;
            end
            step();
        end
        check("busy_after_push", BUSY, 0);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4 * DEPTH && sb_q.size() > 0; i++) step();
        check("drain_empty", sb_q.size(), 0);
        OUT_READY = 1'b0;
    endtask

    // Reference FIFO: applies predicted pushes at the clock edge.
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                sb_q.delete();
                exp_count = 0;
                exp_ovf = 1'b0;
            end else if (exp_push) begin
                if (sb_q.size() < DEPTH) begin
                    sb_q.push_back(exp_entry);
                    if (exp_count < (1 << CNT_W) - 1) exp_count++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on a handshake.
    initial begin
        forever begin
            @(negedge clock);
            check("out_valid", OUT_VALID, sb_q.size() > 0);
            check("level", LEVEL, sb_q.size());
            check("count", COUNT, exp_count);
            check("overflow", OVERFLOW, exp_ovf);
            if (sb_q.size() > 0) begin
                check("out_data", OUT_DATA, sb_q[0]);
                if (OUT_READY) void'(sb_q.pop_front());
            end else begin
                check("out_data_empty", OUT_DATA, 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) OUT_READY = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d8;
        logic [3:0] v;
        step();
        step();
        reset = 1'b0;
        check("reset_busy", BUSY, 0);
        check("reset_count", COUNT, 0);

        // Basic result capture.
        do_reset();
        O_IN = 4'd0;
        session(2, 2, 4'd5, 1'b0);
        step();
        check("t1_data", OUT_DATA, 8'h05);
        check("t1_count", COUNT, 1);
        check("t1_busy", BUSY, 0);
        drain();

        // Timeout entry, then the next run carries seq 1.
        do_reset();
        O_IN = 4'd3;
        session(1, 99, 4'd3, 1'b0);
        step();
        check("t2_timeout_data", OUT_DATA, 8'h83);
        session(1, 0, 4'd7, 1'b0);
        step();
        check("t2_level", LEVEL, 2);
        drain();
        check("t2_count", COUNT, 2);

        // Overflow with consumer stalled.
        do_reset();
        for (int i = 0; i < 9; i++) session(1, 1, diff_val(O_IN), 1'b0);
        check("t3_level", LEVEL, 8);
        check("t3_overflow", OVERFLOW, 1);
        check("t3_count", COUNT, 8);
        drain();

        // Full FIFO with a pop in the push cycle.
        do_reset();
        for (int i = 0; i < 8; i++) session(1, 1, diff_val(O_IN), 1'b0);
        session(1, 1, diff_val(O_IN), 1'b1);
        check("t4_level", LEVEL, 8);
        check("t4_overflow", OVERFLOW, 0);
        check("t4_count", COUNT, 9);
        drain();

        // Abort in WAIT, then START and result change in the same cycle.
        do_reset();
        O_IN = 4'd2;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        step();
        START = 1'b1;
        request(1'b1, O_IN);
        step();
        exp_push = 1'b0;
        check("t5_abort_armed", BUSY, 1);
        step();
        START = 1'b0;
        step();
        O_IN = 4'd9;
        START = 1'b1;
        request(1'b0, O_IN);
        step();
        exp_push = 1'b0;
        check("t5_change_idle", BUSY, 0);
        START = 1'b0;
        check("t5_head", OUT_DATA, 8'h82);
        step();
        check("t5_still_idle", BUSY, 0);
        drain();

        // Reset during WAIT with entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) session(1, 1, diff_val(O_IN), 1'b0);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        check("t6_busy_wait", BUSY, 1);
        do_reset();
        check("t6_level", LEVEL, 0);
        check("t6_valid", OUT_VALID, 0);
        check("t6_busy", BUSY, 0);
        session(1, 1, diff_val(O_IN), 1'b0);
        step();
        d8 = OUT_DATA;
        check("t6_seq_restart", d8[6:4], 0);
        drain();

        // Randomized sessions with a random consumer.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                O_IN = 4'($urandom_range(0, 15));
                step();
            end
            v = 4'($urandom_range(0, 15));
            session($urandom_range(1, 3), $urandom_range(0, 40), v, 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
